// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame-size limits and
// the data-bit-count clamp (also used by the transmitter so both ends agree
// on what an illegal NBits value means).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int NBITS_MIN          = 5;
  localparam int NBITS_MAX          = 8;
  localparam int OVERSAMPLE_DEFAULT = 16;

  // Out-of-range frame sizes fall back to a full byte.
  function automatic logic [3:0] clamp_nbits(input logic [3:0] n);
    if (n < 4'(NBITS_MIN) || n > 4'(NBITS_MAX)) return 4'(NBITS_MAX);
    return n;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Metastability synchronizer: STAGES-deep flop chain, resets to 1 so an
// idle-high serial line shows no spurious edge when reset is released.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   d_i     asynchronous input
//   q_o     synchronized output
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rs232_rx.sv
// RS-232 UART receiver. Recovers 5..8-bit LSB-first frames (1 start,
// N data, 1 stop, no parity) using a shared oversample Tick strobe.
// Ports:
//   Clk       system clock (only clock)
//   Rst_n     asynchronous active-low reset
//   RxEn      receive enable; low aborts any frame in progress
//   Rx        asynchronous serial line, idles high
//   Tick      oversample strobe, one Clk wide
//   NBits     data bits per frame (5..8, others treated as 8)
//   RxData    received data, right-aligned, unused MSBs zero
//   RxDone    one-Clk pulse per completed frame
//   FrameErr  stop bit of the last completed frame was low
module uart_rs232_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       RxEn,
  input  logic       Rx,
  input  logic       Tick,
  input  logic [3:0] NBits,
  output logic [7:0] RxData,
  output logic       RxDone,
  output logic       FrameErr
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  logic          rxs, rxs_d_q, fall;
  rx_state_e     state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    nb_q, nb_d;
  logic [2:0]    nb_last;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    data_q, data_d;
  logic          ferr_q, ferr_d;
  logic          done_q, done_d;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .d_i    (Rx),
    .q_o    (rxs)
  );

  assign fall    = rxs_d_q & ~rxs;
  assign nb_last = 3'(nb_q - 4'd1);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    nb_d    = nb_q;
    sr_d    = sr_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    if (!RxEn && state_q != IDLE) begin
      // Abort: drop the frame, outputs keep the last delivered values.
      state_d = IDLE;
      tick_d  = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (RxEn && fall) begin
            state_d = START;
            tick_d  = '0;
            bit_d   = '0;
            nb_d    = clamp_nbits(NBits);
          end
        end
        START: begin
          if (Tick) begin
            if (tick_q == TICK_MID) begin
              // Line back high at mid start bit means a glitch, not a frame.
              tick_d  = '0;
              state_d = rxs ? IDLE : DATA;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (Tick) begin
            tick_d = tick_q + 1'b1;
            if (tick_q == TICK_LAST) begin
              sr_d  = {rxs, sr_q[7:1]};
              bit_d = bit_q + 1'b1;
              if (bit_q == nb_last) begin
                state_d = STOP;
                tick_d  = '0;
              end
            end
          end
        end
        STOP: begin
          if (Tick) begin
            tick_d = tick_q + 1'b1;
            if (tick_q == TICK_LAST) begin
              // Short frames sit in the top nb bits of sr; right-align them.
              data_d  = sr_q >> (4'd8 - nb_q);
              ferr_d  = ~rxs;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rxs_d_q <= 1'b1;
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      nb_q    <= 4'(NBITS_MAX);
      sr_q    <= '0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rxs_d_q <= rxs;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      nb_q    <= nb_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  assign RxData   = data_q;
  assign RxDone   = done_q;
  assign FrameErr = ferr_q;

endmodule

// File: tb/tb_uart_rs232_rx.sv
module tb_uart_rs232_rx;

  localparam int OS = 16;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       RxEn;
  logic       Rx;
  logic       Tick;
  logic [3:0] NBits;
  logic [7:0] RxData;
  logic       RxDone;
  logic       FrameErr;

  int total = 0;
  int bad   = 0;
  int div   = 4;
  int tdiv_cnt = 0;
  int wide_err = 0;
  logic done_prev = 1'b0;
  logic [8:0] mon_q[$];   // {FrameErr, RxData} per observed RxDone

  uart_rs232_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .RxEn     (RxEn),
    .Rx       (Rx),
    .Tick     (Tick),
    .NBits    (NBits),
    .RxData   (RxData),
    .RxDone   (RxDone),
    .FrameErr (FrameErr)
  );

  always #5 Clk = ~Clk;

  // Tick strobe: one Clk in every div.
  initial begin
    Tick = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      tdiv_cnt = (tdiv_cnt + 1 >= div) ? 0 : tdiv_cnt + 1;
      Tick = (tdiv_cnt == 0);
    end
  end

  // Monitor: collect delivered frames, flag RxDone wider than one Clk.
  initial begin
    forever begin
      @(negedge Clk);
      if (RxDone) begin
        if (done_prev) wide_err++;
        mon_q.push_back({FrameErr, RxData});
      end
      done_prev = RxDone;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_bit(input int n);
    repeat (n * OS * div) @(posedge Clk);
  endtask

  // Drive one frame at exactly OS Ticks per bit, then idle-high bits.
  task automatic send_frame(input logic [7:0] d, input int nb, input logic stop, input int idle);
    Rx = 1'b0; wait_bit(1);
    for (int i = 0; i < nb; i++) begin
      Rx = d[i]; wait_bit(1);
    end
    Rx = stop; wait_bit(1);
    Rx = 1'b1; wait_bit(idle);
  endtask

  task automatic expect_frame(input string nm, input logic [7:0] ed, input logic ef);
    chk({nm, "_count"}, mon_q.size(), 1);
    if (mon_q.size() > 0) begin
      logic [8:0] r;
      r = mon_q.pop_front();
      chk({nm, "_data"}, r[7:0], ed);
      chk({nm, "_ferr"}, r[8], ef);
    end
    mon_q.delete();
  endtask

  // Reference: effective size and delivered value from the frame rules.
  function automatic int model_nb(input logic [3:0] n);
    return (n < 5 || n > 8) ? 8 : int'(n);
  endfunction

  function automatic logic [7:0] model_data(input logic [7:0] d, input int nb);
    int m;
    m = (1 << nb) - 1;
    return d & m[7:0];
  endfunction

  typedef struct {
    logic [3:0] nbits;
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'd8,  8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{4'd7,  8'h5A, 1'b1, 8'h5A, 1'b0};
    vecs[2] = '{4'd5,  8'h13, 1'b1, 8'h13, 1'b0};
    vecs[3] = '{4'd8,  8'h00, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{4'd8,  8'h81, 1'b1, 8'h81, 1'b0};
    vecs[5] = '{4'd12, 8'hF0, 1'b1, 8'hF0, 1'b0};
    vecs[6] = '{4'd6,  8'hFF, 1'b1, 8'h3F, 1'b0};
    vecs[7] = '{4'd0,  8'h96, 1'b1, 8'h96, 1'b0};

    Rst_n = 1'b0; RxEn = 1'b0; Rx = 1'b1; NBits = 4'd8;
    repeat (3) @(posedge Clk);
    #2;
    chk("reset_data", RxData, 0);
    chk("reset_done", RxDone, 0);
    chk("reset_ferr", FrameErr, 0);
    Rst_n = 1'b1;
    RxEn  = 1'b1;
    wait_bit(1);
    chk("idle_no_done", mon_q.size(), 0);

    // Table vectors; a low stop bit gets a high gap before the next frame.
    for (int v = 0; v < 8; v++) begin
      NBits = vecs[v].nbits;
      send_frame(vecs[v].data, model_nb(vecs[v].nbits), vecs[v].stop, 1);
      expect_frame($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_ferr);
    end

    // Glitch shorter than half a bit: false start, nothing delivered.
    NBits = 4'd8;
    Rx = 1'b0;
    repeat (4 * div) @(posedge Clk);
    Rx = 1'b1;
    wait_bit(1);
    chk("glitch_no_done", mon_q.size(), 0);
    chk("glitch_data_kept", RxData, 8'h96);
    send_frame(8'h3C, 8, 1'b1, 1);
    expect_frame("after_glitch", 8'h3C, 1'b0);

    // Abort by RxEn=0 in the middle of data bit 3.
    begin
      logic [7:0] d;
      d = 8'h55;
      Rx = 1'b0; wait_bit(1);
      for (int i = 0; i < 3; i++) begin Rx = d[i]; wait_bit(1); end
      Rx = d[3];
      repeat (OS / 2 * div) @(posedge Clk);
      RxEn = 1'b0;
      repeat (OS / 2 * div) @(posedge Clk);
      for (int i = 4; i < 8; i++) begin Rx = d[i]; wait_bit(1); end
      Rx = 1'b1; wait_bit(2);
      RxEn = 1'b1;
      wait_bit(1);
      chk("abort_no_done", mon_q.size(), 0);
      chk("abort_data_kept", RxData, 8'h3C);
      chk("abort_ferr_kept", FrameErr, 0);
    end
    send_frame(8'hC3, 8, 1'b1, 1);
    expect_frame("after_abort", 8'hC3, 1'b0);

    // Reset in the middle of a frame clears outputs without waiting for Clk.
    send_frame(8'h7E, 8, 1'b0, 1);
    expect_frame("pre_reset", 8'h7E, 1'b1);
    Rx = 1'b0; wait_bit(1);
    Rx = 1'b1; wait_bit(1);
    @(negedge Clk); #2;
    Rst_n = 1'b0;
    #1;
    chk("midrst_data", RxData, 0);
    chk("midrst_ferr", FrameErr, 0);
    chk("midrst_done", RxDone, 0);
    Rx = 1'b1;
    repeat (4) @(posedge Clk);
    Rst_n = 1'b1;
    wait_bit(8);
    chk("midrst_no_done", mon_q.size(), 0);

    // Back-to-back frames, Tick every Clk.
    div = 1;
    repeat (4) @(posedge Clk);
    send_frame(8'h11, 8, 1'b1, 0);
    send_frame(8'h22, 8, 1'b1, 1);
    chk("b2b_count", mon_q.size(), 2);
    if (mon_q.size() == 2) begin
      chk("b2b_first", mon_q[0], {1'b0, 8'h11});
      chk("b2b_second", mon_q[1], {1'b0, 8'h22});
    end
    mon_q.delete();

    // Randomized frames against the reference model.
    for (int f = 0; f < 24; f++) begin
      logic [3:0] nbits;
      logic [7:0] d;
      logic       stop;
      int         idle;
      int         nb;
      if (f % 6 == 0) begin
        div = (f % 12 == 0) ? 4 : 1;
        wait_bit(1);
      end
      nbits = 4'($urandom_range(0, 15));
      d     = 8'($urandom);
      stop  = ($urandom_range(0, 3) != 0);
      idle  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      nb    = model_nb(nbits);
      NBits = nbits;
      send_frame(d, nb, stop, idle);
      expect_frame($sformatf("rnd%0d", f), model_data(d, nb), ~stop);
    end

    chk("done_one_clk", wide_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
